// File: rtl/ysyx_24110006_axi_pkg.sv
// rtl/ysyx_24110006_axi_pkg.sv - shared AXI read-path encodings, FSM states and address helpers
package ysyx_24110006_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } state_t;

  // Only power-of-two beat counts of 2..16 form a legal wrap window.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // A request the responder cannot honour as a whole: wide beats, reserved burst, bad wrap length.
  function automatic logic txn_slverr(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst);
    logic w_bad;
    w_bad = (size > 3'd2) || (burst == 2'd3);
    if (burst == BURST_WRAP && !wrap_len_ok(len)) w_bad = 1'b1;
    return w_bad;
  endfunction

  // Address of the beat following addr for the given burst shape.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] w_inc;
    logic [31:0] w_span;
    logic [31:0] w_next;
    w_inc  = 32'd1 << size;
    w_span = w_inc * ({24'd0, len} + 32'd1);
    case (burst)
      BURST_FIXED: w_next = addr;
      BURST_INCR:  w_next = addr + w_inc;
      BURST_WRAP:  w_next = (addr & ~(w_span - 32'd1)) | ((addr + w_inc) & (w_span - 32'd1));
      default:     w_next = addr;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/ysyx_24110006_lfsr8.sv
// rtl/ysyx_24110006_lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module ysyx_24110006_lfsr8 #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       i_clock,
  input  logic       i_reset,
  output logic [7:0] o_value
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb    = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
  assign o_value = r_q;

  // Shift one step every cycle once out of reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

endmodule

// File: rtl/ysyx_24110006_axi_rd_sram.sv
// rtl/ysyx_24110006_axi_rd_sram.sv - AXI4 read responder backed by a word SRAM with access delay
module ysyx_24110006_axi_rd_sram
  import ysyx_24110006_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          FIRST_LAT = 2,
  parameter logic [7:0]  RAND_MASK = 8'h00
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [1:0]  o_axi_rresp,
  output logic [3:0]  o_axi_rid,
  output logic        o_axi_rlast,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;
  localparam logic [8:0]  FIRST_DLY = 9'(FIRST_LAT);

  logic [31:0] r_mem [DEPTH];

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic [8:0]  r_dly;
  logic        r_slverr;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic        r_rlast;

  logic [7:0]  w_lfsr;
  logic [8:0]  w_dly;
  logic        w_ar_hs;
  logic        w_ar_slverr;
  logic [31:0] w_next_addr;
  logic        w_load;
  logic [31:0] w_beat_addr;
  logic        w_beat_slverr;
  logic        w_beat_last;
  logic [31:0] w_beat_off;
  logic        w_beat_inr;
  logic [AW-1:0] w_beat_idx;
  logic [31:0] w_wr_off;
  logic        w_wr_inr;
  logic [AW-1:0] w_wr_idx;

  ysyx_24110006_lfsr8 #(
    .SEED (8'h5A)
  ) u_lfsr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_value (w_lfsr)
  );

  assign o_axi_arready = (r_state == IDLE) && !i_reset;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rid     = r_rid;
  assign o_axi_rlast   = r_rlast;

  assign w_ar_hs     = i_axi_arvalid && o_axi_arready;
  assign w_ar_slverr = txn_slverr(i_axi_arsize, i_axi_arlen, i_axi_arburst);
  assign w_dly       = FIRST_DLY + {1'b0, w_lfsr & RAND_MASK};
  assign w_next_addr = next_addr(r_addr, r_size, r_len, r_burst);

  // Select which address/flags feed the next presented beat and whether one is loaded now.
  always_comb begin
    w_load        = 1'b0;
    w_beat_addr   = r_addr;
    w_beat_slverr = r_slverr;
    w_beat_last   = 1'b0;
    case (r_state)
      IDLE: begin
        w_load        = w_ar_hs && (w_dly == 9'd0);
        w_beat_addr   = i_axi_araddr;
        w_beat_slverr = w_ar_slverr;
        w_beat_last   = (i_axi_arlen == 8'd0);
      end
      WAIT: begin
        w_load      = (r_dly == 9'd0);
        w_beat_last = (r_cnt == 8'd0);
      end
      DATA: begin
        w_load      = i_axi_rready && !r_rlast;
        w_beat_addr = w_next_addr;
        w_beat_last = (r_cnt == 8'd1);
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  assign w_beat_off = w_beat_addr - BASE_ADDR;
  assign w_beat_inr = {1'b0, w_beat_off} < MEM_BYTES;
  assign w_beat_idx = w_beat_off[AW+1:2];

  assign w_wr_off = i_wr_addr - BASE_ADDR;
  assign w_wr_inr = {1'b0, w_wr_off} < MEM_BYTES;
  assign w_wr_idx = w_wr_off[AW+1:2];

  // Preload port; the array is never reset so contents survive a mid-burst reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en && w_wr_inr) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  // Request/delay/data FSM with registered R-channel outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_addr   <= 32'd0;
      r_len    <= 8'd0;
      r_size   <= 3'd0;
      r_burst  <= 2'd0;
      r_cnt    <= 8'd0;
      r_dly    <= 9'd0;
      r_slverr <= 1'b0;
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rid    <= 4'd0;
      r_rlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_addr   <= i_axi_araddr;
            r_len    <= i_axi_arlen;
            r_size   <= i_axi_arsize;
            r_burst  <= i_axi_arburst;
            r_cnt    <= i_axi_arlen;
            r_rid    <= i_axi_arid;
            r_slverr <= w_ar_slverr;
            if (w_dly == 9'd0) begin
              r_state <= DATA;
            end else begin
              r_state <= WAIT;
              r_dly   <= w_dly - 9'd1;
            end
          end
        end
        WAIT: begin
          if (r_dly == 9'd0) begin
            r_state <= DATA;
          end else begin
            r_dly <= r_dly - 9'd1;
          end
        end
        DATA: begin
          if (i_axi_rready) begin
            if (r_rlast) begin
              r_state  <= IDLE;
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt - 8'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_load) begin
        r_rvalid <= 1'b1;
        r_rlast  <= w_beat_last;
        if (w_beat_slverr) begin
          r_rresp <= RESP_SLVERR;
          r_rdata <= 32'd0;
        end else if (!w_beat_inr) begin
          r_rresp <= RESP_DECERR;
          r_rdata <= 32'd0;
        end else begin
          r_rresp <= RESP_OKAY;
          r_rdata <= r_mem[w_beat_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_axi_rd_sram.sv
// tb/tb_ysyx_24110006_axi_rd_sram.sv - directed table-driven bench for the AXI read SRAM
module tb_ysyx_24110006_axi_rd_sram;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_axi_araddr = 32'd0;
  logic        i_axi_arvalid = 1'b0;
  logic        o_axi_arready;
  logic [3:0]  i_axi_arid = 4'd0;
  logic [7:0]  i_axi_arlen = 8'd0;
  logic [2:0]  i_axi_arsize = 3'd0;
  logic [1:0]  i_axi_arburst = 2'd0;
  logic [31:0] o_axi_rdata;
  logic        o_axi_rvalid;
  logic        i_axi_rready = 1'b1;
  logic [1:0]  o_axi_rresp;
  logic [3:0]  o_axi_rid;
  logic        o_axi_rlast;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_addr = 32'd0;
  logic [31:0] i_wr_data = 32'd0;

  int checks = 0;
  int errors = 0;

  ysyx_24110006_axi_rd_sram dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arvalid (i_axi_arvalid),
    .o_axi_arready (o_axi_arready),
    .i_axi_arid    (i_axi_arid),
    .i_axi_arlen   (i_axi_arlen),
    .i_axi_arsize  (i_axi_arsize),
    .i_axi_arburst (i_axi_arburst),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rvalid  (o_axi_rvalid),
    .i_axi_rready  (i_axi_rready),
    .o_axi_rresp   (o_axi_rresp),
    .o_axi_rid     (o_axi_rid),
    .o_axi_rlast   (o_axi_rlast),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [3:0][31:0] d;
    logic [3:0][1:0]  r;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input logic [3:0] id,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [1:0] r0, input logic [1:0] r1,
                              input logic [1:0] r2, input logic [1:0] r3);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    return v;
  endfunction

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  // Present one AR until accepted; returns in the cycle after the handshake.
  task automatic issue_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id);
    int n;
    i_axi_araddr = a; i_axi_arlen = l; i_axi_arsize = s; i_axi_arburst = b; i_axi_arid = id;
    i_axi_arvalid = 1'b1;
    n = 0;
    while (!o_axi_arready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ar_timeout", 32'd0, 32'd1);
    tick();
    i_axi_arvalid = 1'b0;
  endtask

  // Wait for rvalid, returning how many cycles after the handshake it appeared.
  task automatic wait_rvalid(output int lat);
    lat = 1;
    while (!o_axi_rvalid && lat < 50) begin
      tick();
      lat++;
    end
    if (lat >= 50) check("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    i_axi_rready = 1'b1;
    issue_ar(v.addr, v.len, v.size, v.burst, v.id);
    wait_rvalid(lat);
    check($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
    for (int b = 0; b <= int'(v.len); b++) begin
      check($sformatf("v%0d_b%0d_rvalid", k, b), {31'd0, o_axi_rvalid}, 32'd1);
      check($sformatf("v%0d_b%0d_rdata", k, b), o_axi_rdata, v.d[b]);
      check($sformatf("v%0d_b%0d_rresp", k, b), {30'd0, o_axi_rresp}, {30'd0, v.r[b]});
      check($sformatf("v%0d_b%0d_rlast", k, b), {31'd0, o_axi_rlast}, {31'd0, b == int'(v.len)});
      check($sformatf("v%0d_b%0d_rid", k, b), {28'd0, o_axi_rid}, {28'd0, v.id});
      tick();
    end
    check($sformatf("v%0d_idle_rvalid", k), {31'd0, o_axi_rvalid}, 32'd0);
    check($sformatf("v%0d_idle_arready", k), {31'd0, o_axi_arready}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] exp_d;

    vecs[0]  = mk(32'h8000_0000, 8'd0, 3'd2, 2'd0, 4'h1, 32'h0000_0413, 0, 0, 0, 2'd0, 0, 0, 0);
    vecs[1]  = mk(32'h8000_0010, 8'd3, 3'd2, 2'd1, 4'h2, w(4), w(5), w(6), w(7), 2'd0, 2'd0, 2'd0, 2'd0);
    vecs[2]  = mk(32'h8000_0018, 8'd3, 3'd2, 2'd2, 4'h4, w(6), w(7), w(4), w(5), 2'd0, 2'd0, 2'd0, 2'd0);
    vecs[3]  = mk(32'h8000_0018, 8'd2, 3'd2, 2'd2, 4'h5, 0, 0, 0, 0, 2'd2, 2'd2, 2'd2, 2'd0);
    vecs[4]  = mk(32'h7FFF_FFFC, 8'd0, 3'd2, 2'd1, 4'h6, 0, 0, 0, 0, 2'd3, 0, 0, 0);
    vecs[5]  = mk(32'h8000_4000, 8'd0, 3'd2, 2'd1, 4'h7, 0, 0, 0, 0, 2'd3, 0, 0, 0);
    vecs[6]  = mk(32'h8000_3FFC, 8'd1, 3'd2, 2'd1, 4'h8, 32'hDEAD_BEEF, 0, 0, 0, 2'd0, 2'd3, 0, 0);
    vecs[7]  = mk(32'h8000_0008, 8'd2, 3'd2, 2'd0, 4'h9, w(2), w(2), w(2), 0, 2'd0, 2'd0, 2'd0, 0);
    vecs[8]  = mk(32'h8000_0000, 8'd0, 3'd3, 2'd1, 4'hB, 0, 0, 0, 0, 2'd2, 0, 0, 0);
    vecs[9]  = mk(32'h8000_0000, 8'd0, 3'd2, 2'd3, 4'hC, 0, 0, 0, 0, 2'd2, 0, 0, 0);
    vecs[10] = mk(32'h8000_0004, 8'd3, 3'd0, 2'd1, 4'hD, w(1), w(1), w(1), w(1), 2'd0, 2'd0, 2'd0, 2'd0);
    vecs[11] = mk(32'h8000_0006, 8'd3, 3'd1, 2'd2, 4'hE, w(1), 32'h0000_0413, 32'h0000_0413, w(1),
                  2'd0, 2'd0, 2'd0, 2'd0);

    // Reset state.
    #2;
    check("rst_rvalid", {31'd0, o_axi_rvalid}, 32'd0);
    check("rst_rlast", {31'd0, o_axi_rlast}, 32'd0);
    check("rst_rresp", {30'd0, o_axi_rresp}, 32'd0);
    check("rst_rdata", o_axi_rdata, 32'd0);
    check("rst_rid", {28'd0, o_axi_rid}, 32'd0);
    check("rst_arready", {31'd0, o_axi_arready}, 32'd0);
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    check("post_rst_arready", {31'd0, o_axi_arready}, 32'd1);

    preload(32'h8000_0000, 32'h0000_0413);
    for (int i = 1; i < 16; i++) preload(32'h8000_0000 + 32'(4 * i), w(i));
    preload(32'h8000_3FFC, 32'hDEAD_BEEF);

    for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

    // Stalled INCR burst: data held while rready low.
    i_axi_rready = 1'b0;
    issue_ar(32'h8000_0010, 8'd3, 3'd2, 2'd1, 4'h2);
    wait_rvalid(lat);
    for (int b = 0; b < 4; b++) begin
      exp_d = w(4 + b);
      check($sformatf("stall_b%0d_rdata", b), o_axi_rdata, exp_d);
      check($sformatf("stall_b%0d_rlast", b), {31'd0, o_axi_rlast}, {31'd0, b == 3});
      tick();
      check($sformatf("stall_b%0d_hold_rvalid", b), {31'd0, o_axi_rvalid}, 32'd1);
      check($sformatf("stall_b%0d_hold_rdata", b), o_axi_rdata, exp_d);
      i_axi_rready = 1'b1;
      tick();
      i_axi_rready = 1'b0;
    end
    check("stall_done_rvalid", {31'd0, o_axi_rvalid}, 32'd0);
    i_axi_rready = 1'b1;

    // arvalid held across a burst: second request waits for IDLE.
    i_axi_araddr = 32'h8000_0000; i_axi_arlen = 8'd1; i_axi_arsize = 3'd2;
    i_axi_arburst = 2'd1; i_axi_arid = 4'h3; i_axi_arvalid = 1'b1;
    tick();
    i_axi_araddr = 32'h8000_0004; i_axi_arlen = 8'd0; i_axi_arid = 4'hA;
    n = 0;
    while (!(o_axi_rvalid && o_axi_rlast) && n < 50) begin
      check($sformatf("hold_arready_c%0d", n), {31'd0, o_axi_arready}, 32'd0);
      if (o_axi_rvalid) check($sformatf("hold_rid3_c%0d", n), {28'd0, o_axi_rid}, 32'h3);
      tick();
      n++;
    end
    check("hold_last_rid", {28'd0, o_axi_rid}, 32'h3);
    check("hold_last_arready", {31'd0, o_axi_arready}, 32'd0);
    tick();
    check("hold_after_arready", {31'd0, o_axi_arready}, 32'd1);
    tick();
    i_axi_arvalid = 1'b0;
    wait_rvalid(lat);
    check("second_rid", {28'd0, o_axi_rid}, 32'hA);
    check("second_rdata", o_axi_rdata, w(1));
    check("second_rlast", {31'd0, o_axi_rlast}, 32'd1);
    tick();

    // Reset in the middle of a 4-beat burst.
    issue_ar(32'h8000_0010, 8'd3, 3'd2, 2'd1, 4'h5);
    wait_rvalid(lat);
    tick();
    check("mid_b2_rdata", o_axi_rdata, w(5));
    i_reset = 1'b1;
    #1;
    check("mid_rst_rvalid", {31'd0, o_axi_rvalid}, 32'd0);
    check("mid_rst_rdata", o_axi_rdata, 32'd0);
    check("mid_rst_arready", {31'd0, o_axi_arready}, 32'd0);
    tick();
    i_reset = 1'b0;
    #1;
    check("mid_rel_arready", {31'd0, o_axi_arready}, 32'd1);
    check("mid_rel_rvalid", {31'd0, o_axi_rvalid}, 32'd0);

    // Out-of-range preload must not alias onto word 0.
    preload(32'h8000_4000, 32'h1234_5678);
    run_vec(20, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
